// File: rtl/freq_meter_pkg.sv
// Shared encodings for the frequency-meter gate sequencer: FSM states, range codes
// and the auto-range step rule.
package freq_meter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_GATE  = 3'd2,
    ST_LATCH = 3'd3,
    ST_EVAL  = 3'd4,
    ST_CLEAR = 3'd5,
    ST_HOLD  = 3'd6
  } gate_state_e;

  localparam logic [1:0] RANGE_1MS   = 2'd0;
  localparam logic [1:0] RANGE_10MS  = 2'd1;
  localparam logic [1:0] RANGE_100MS = 2'd2;
  localparam logic [1:0] RANGE_1S    = 2'd3;
  localparam logic [1:0] MAX_RANGE   = 2'd3;

  localparam int HOLD_W = 25;

  // Overflow shortens the gate before underrange lengthens it; both saturate.
  function automatic logic [1:0] next_range(
    input logic       auto_mode,
    input logic       ovf,
    input logic       msd,
    input logic [1:0] cur_rng,
    input logic [1:0] man_rng
  );
    logic [1:0] nxt;
    if (!auto_mode) begin
      nxt = man_rng;
    end else if (ovf && (cur_rng != RANGE_1MS)) begin
      nxt = cur_rng - 2'd1;
    end else if (msd && (cur_rng != MAX_RANGE)) begin
      nxt = cur_rng + 2'd1;
    end else begin
      nxt = cur_rng;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tb_edge_sel.sv
// Timebase selector: registers the four timebases, muxes one by range and
// flags its rising edge one cycle after the input edge.
module tb_edge_sel
  import freq_meter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tb_1hz,
  input  logic       tb_10hz,
  input  logic       tb_100hz,
  input  logic       tb_1khz,
  input  logic [1:0] range_sel,
  output logic       rise
);

  logic [3:0] tb_r;
  logic       tb_sel_s;
  logic       tb_sel_d_r;

  // Capture the timebases and the previously selected level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tb_r       <= 4'b0000;
      tb_sel_d_r <= 1'b0;
    end else begin
      tb_r       <= {tb_1hz, tb_10hz, tb_100hz, tb_1khz};
      tb_sel_d_r <= tb_sel_s;
    end
  end

  // Range-to-timebase mux.
  always_comb begin
    tb_sel_s = 1'b0;
    case (range_sel)
      RANGE_1MS:   tb_sel_s = tb_r[0];
      RANGE_10MS:  tb_sel_s = tb_r[1];
      RANGE_100MS: tb_sel_s = tb_r[2];
      RANGE_1S:    tb_sel_s = tb_r[3];
      default:     tb_sel_s = 1'b0;
    endcase
  end

  assign rise = tb_sel_s & ~tb_sel_d_r;

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate/range sequencer: opens a one-timebase-period count gate, then latches,
// evaluates auto-range and clears the external BCD counter before holding.
module freq_gate_ctrl
  import freq_meter_pkg::*;
#(
  parameter int         HOLD_CYCLES = 25_000_000,
  parameter logic [1:0] INIT_RANGE  = 2'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tb_1hz,
  input  logic       tb_10hz,
  input  logic       tb_100hz,
  input  logic       tb_1khz,
  input  logic       run,
  input  logic       auto_en,
  input  logic [1:0] man_range,
  input  logic       cnt_overflow,
  input  logic       cnt_msd_zero,
  output logic       gate_en,
  output logic       cnt_latch,
  output logic       cnt_clr,
  output logic       result_valid,
  output logic [1:0] range_out,
  output logic       over_range,
  output logic       under_range
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  gate_state_e       state_r;
  logic [1:0]        range_r;
  logic              ovf_r;
  logic              msd_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic              rise_s;

  tb_edge_sel u_edge_sel (
    .clk       (clk),
    .reset     (reset),
    .tb_1hz    (tb_1hz),
    .tb_10hz   (tb_10hz),
    .tb_100hz  (tb_100hz),
    .tb_1khz   (tb_1khz),
    .range_sel (range_r),
    .rise      (rise_s)
  );

  // Sequencer; each output is set alongside the transition into the state that owns it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      range_r      <= INIT_RANGE;
      ovf_r        <= 1'b0;
      msd_r        <= 1'b0;
      hold_cnt_r   <= HOLD_ZERO;
      gate_en      <= 1'b0;
      cnt_latch    <= 1'b0;
      cnt_clr      <= 1'b1;
      result_valid <= 1'b0;
      range_out    <= INIT_RANGE;
      over_range   <= 1'b0;
      under_range  <= 1'b0;
    end else begin
      gate_en      <= 1'b0;
      cnt_latch    <= 1'b0;
      cnt_clr      <= 1'b0;
      result_valid <= 1'b0;
      if (!run) begin
        state_r <= ST_IDLE;
        cnt_clr <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_ARM;
          end
          ST_ARM: begin
            if (rise_s) begin
              state_r <= ST_GATE;
              gate_en <= 1'b1;
            end else begin
              state_r <= ST_ARM;
            end
          end
          ST_GATE: begin
            if (rise_s) begin
              state_r   <= ST_LATCH;
              cnt_latch <= 1'b1;
            end else begin
              state_r <= ST_GATE;
              gate_en <= 1'b1;
            end
          end
          ST_LATCH: begin
            // Result flags are published on entry to EVAL so they line up with result_valid.
            state_r      <= ST_EVAL;
            result_valid <= 1'b1;
            ovf_r        <= cnt_overflow;
            msd_r        <= cnt_msd_zero;
            range_out    <= range_r;
            over_range   <= cnt_overflow & (range_r == RANGE_1MS);
            under_range  <= cnt_msd_zero & ~cnt_overflow & (range_r == MAX_RANGE);
          end
          ST_EVAL: begin
            state_r <= ST_CLEAR;
            cnt_clr <= 1'b1;
            range_r <= next_range(auto_en, ovf_r, msd_r, range_r, man_range);
          end
          ST_CLEAR: begin
            state_r    <= ST_HOLD;
            hold_cnt_r <= HOLD_LOAD;
          end
          ST_HOLD: begin
            if (hold_cnt_r == HOLD_ZERO) begin
              state_r <= ST_ARM;
            end else begin
              state_r    <= ST_HOLD;
              hold_cnt_r <= hold_cnt_r - HOLD_ONE;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            cnt_clr <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl: timebase history plus a measurement-level
// reference model (gate spans rise-to-rise of the selected timebase, range rules).
module tb_freq_gate_ctrl;

  localparam int HOLD = 4;
  localparam int MAXT = 32768;

  logic       clk = 1'b0;
  logic       reset;
  logic       tb_1hz, tb_10hz, tb_100hz, tb_1khz;
  logic       run, auto_en;
  logic [1:0] man_range;
  logic       cnt_overflow, cnt_msd_zero;
  logic       gate_en, cnt_latch, cnt_clr, result_valid;
  logic [1:0] range_out;
  logic       over_range, under_range;

  freq_gate_ctrl #(.HOLD_CYCLES(HOLD), .INIT_RANGE(2'd3)) dut (
    .clk          (clk),
    .reset        (reset),
    .tb_1hz       (tb_1hz),
    .tb_10hz      (tb_10hz),
    .tb_100hz     (tb_100hz),
    .tb_1khz      (tb_1khz),
    .run          (run),
    .auto_en      (auto_en),
    .man_range    (man_range),
    .cnt_overflow (cnt_overflow),
    .cnt_msd_zero (cnt_msd_zero),
    .gate_en      (gate_en),
    .cnt_latch    (cnt_latch),
    .cnt_clr      (cnt_clr),
    .result_valid (result_valid),
    .range_out    (range_out),
    .over_range   (over_range),
    .under_range  (under_range)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         tick = 0;
  int         arm_tick = 0;
  int         range_m = 3;
  bit         dead = 1'b0;
  bit         jitter = 1'b0;
  logic [3:0] lvl = 4'b0000;            // bit r = timebase used by range r
  int         hcnt [4];
  int         half [4] = '{10, 14, 19, 25};
  logic [3:0] hist [0:MAXT-1];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (tick %0d)", tag, obs, exp, tick);
    end
  endtask

  // One clock: advance to the falling edge, then drive the next timebase levels.
  task automatic step();
    @(negedge clk);
    tick++;
    for (int s = 0; s < 4; s++) begin
      if (hcnt[s] <= 1) begin
        lvl[s]  = ~lvl[s];
        hcnt[s] = jitter ? half[s] + int'($urandom_range(6, 0)) - 3 : half[s];
      end else begin
        hcnt[s]--;
      end
    end
    {tb_1hz, tb_10hz, tb_100hz, tb_1khz} = lvl;
    hist[tick % MAXT] = lvl;
  endtask

  function automatic bit rise_at(input int x);
    return hist[x % MAXT][range_m] & ~hist[(x - 1) % MAXT][range_m];
  endfunction

  // Expects reset asserted; releases it with run low, checks idle state, then starts.
  task automatic bring_up();
    step();
    check_eq("rst_outputs", {gate_en, cnt_latch, cnt_clr, result_valid, over_range, under_range},
             6'b001000);
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_eq("rst_range_out", range_out, 3);
    check_eq("idle_outputs", {gate_en, cnt_latch, cnt_clr, result_valid}, 4'b0010);
    range_m = 3;
    run = 1'b1;
    step();
    arm_tick = tick;
  endtask

  // One measurement starting in ARM at arm_tick; abort_at>=0 drops run (kind 0)
  // or asserts reset (kind 1) after that many gate cycles.
  task automatic measure(input int abort_at, input int nominal, input int kind);
    int pred, obs, g, n;
    bit exp_over, exp_under;
    if (dead) return;
    pred = -1; obs = -1;
    for (int k = 0; k < 400; k++) begin
      if (gate_en) begin obs = tick; break; end
      if (pred < 0 && rise_at(tick - 1)) pred = tick + 1;
      step();
    end
    check_eq("gate_start", obs, pred);
    if (obs < 0) begin dead = 1'b1; return; end
    g = obs; pred = -1; obs = -1; n = 0;
    for (int k = 0; k < 400; k++) begin
      if (!gate_en) begin obs = tick; break; end
      if (abort_at >= 0 && n == abort_at) begin
        if (kind == 1) begin
          reset = 1'b0;
          run = 1'b0;
          #1;
          check_eq("rst_mid_gate", {gate_en, cnt_clr}, 2'b01);
          bring_up();
        end else begin
          run = 1'b0;
          step();
          check_eq("abort_idle", {gate_en, cnt_clr}, 2'b01);
          for (int i = 0; i < 3; i++) begin
            step();
            check_eq("abort_quiet", {cnt_latch, result_valid, cnt_clr}, 3'b001);
          end
          run = 1'b1;
          step();
          arm_tick = tick;
        end
        return;
      end
      if (pred < 0 && rise_at(tick - 1)) pred = tick + 1;
      n++;
      step();
    end
    check_eq("gate_end", obs, pred);
    if (obs < 0) begin dead = 1'b1; return; end
    if (nominal > 0) check_eq("gate_len", obs - g, nominal);
    check_eq("latch_pulse", {cnt_latch, result_valid, cnt_clr, gate_en}, 4'b1000);
    exp_over  = cnt_overflow && (range_m == 0);
    exp_under = cnt_msd_zero && !cnt_overflow && (range_m == 3);
    step();
    check_eq("valid_pulse", {cnt_latch, result_valid, cnt_clr, gate_en}, 4'b0100);
    check_eq("range_out", range_out, range_m);
    check_eq("over_range", over_range, exp_over);
    check_eq("under_range", under_range, exp_under);
    if (!auto_en) range_m = man_range;
    else if (cnt_overflow && range_m > 0) range_m = range_m - 1;
    else if (cnt_msd_zero && range_m < 3) range_m = range_m + 1;
    step();
    check_eq("clr_pulse", {cnt_latch, result_valid, cnt_clr, gate_en}, 4'b0010);
    for (int h = 0; h < HOLD; h++) begin
      step();
      check_eq("hold_quiet", {cnt_latch, result_valid, cnt_clr, gate_en}, 4'b0000);
    end
    step();
    arm_tick = tick;
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; auto_en = 1'b0; man_range = 2'd0;
    cnt_overflow = 1'b0; cnt_msd_zero = 1'b0;
    {tb_1hz, tb_10hz, tb_100hz, tb_1khz} = 4'b0000;
    for (int s = 0; s < 4; s++) hcnt[s] = int'($urandom_range(half[s], 1));
    bring_up();

    // Manual range 0: first result still at range 3, next one with a 20-cycle gate.
    measure(-1, -1, 0);
    measure(-1, 20, 0);
    // Reset in the middle of a range-0 gate.
    measure(6, -1, 1);
    // Overflow every gate from range 3, then underrange every gate from range 0.
    auto_en = 1'b1; cnt_overflow = 1'b1;
    for (int i = 0; i < 5; i++) measure(-1, -1, 0);
    cnt_overflow = 1'b0; cnt_msd_zero = 1'b1;
    for (int i = 0; i < 5; i++) measure(-1, -1, 0);
    // Move to range 2, then both flags set: overflow must win.
    auto_en = 1'b0; man_range = 2'd2; cnt_msd_zero = 1'b0;
    measure(-1, -1, 0);
    auto_en = 1'b1; cnt_overflow = 1'b1; cnt_msd_zero = 1'b1;
    measure(-1, -1, 0);
    cnt_overflow = 1'b0; cnt_msd_zero = 1'b0;
    measure(-1, -1, 0);
    // run dropped mid-gate, then a normal measurement at the unchanged range.
    measure(5, -1, 0);
    measure(-1, -1, 0);

    jitter = 1'b1;
    for (int i = 0; i < 40; i++) begin
      auto_en      = ($urandom_range(3, 0) != 0);
      man_range    = 2'($urandom_range(3, 0));
      cnt_overflow = ($urandom_range(2, 0) == 0);
      cnt_msd_zero = ($urandom_range(1, 0) == 1);
      if ($urandom_range(7, 0) == 0) measure(int'($urandom_range(12, 0)), -1, 0);
      else measure(-1, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
